// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op codes, FSM encodings and request payload.
package shift_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [SHAMT_W-1:0] b;
        logic [OP_W-1:0]    op;
    } shift_req_t;

    // Right-shift result is taken for SRL/SRA; SLL and the reserved code use the left result.
    function automatic logic use_rshift(input logic [OP_W-1:0] op);
        return (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/shifter.sv
// 32-bit combinational barrel shifter: logical left, and right with a fill bit (extn).
module shifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] b,
    input  logic               extn,
    output logic [DATA_W-1:0]  lshift_s,
    output logic [DATA_W-1:0]  rshift_s
);

    logic [DATA_W-1:0] r1, r2, r4, r8;

    assign lshift_s = a << b;

    // Five right stages; extn fills vacated MSBs so SRA and SRL share one path.
    assign r1       = b[0] ? {extn, a[31:1]}           : a;
    assign r2       = b[1] ? {{2{extn}}, r1[31:2]}     : r1;
    assign r4       = b[2] ? {{4{extn}}, r2[31:4]}     : r2;
    assign r8       = b[3] ? {{8{extn}}, r4[31:8]}     : r4;
    assign rshift_s = b[4] ? {{16{extn}}, r8[31:16]}   : r8;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter among N_REQ requesters, one transaction in flight.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DATA_W-1:0]    req_a,
    input  logic [N_REQ*SHAMT_W-1:0]   req_b,
    input  logic [N_REQ*OP_W-1:0]      req_op,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       busy
);

    localparam int unsigned IDW = $clog2(N_REQ);

    logic [1:0]        state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, id_q, grant;
    shift_req_t        req_sel, op_q;
    logic              accept, rsp_done, extn;
    logic [DATA_W-1:0] lshift_s, rshift_s, result;

    // First valid requester after ptr, wrapping modulo N_REQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [IDW-1:0]   ptr);
        logic [IDW-1:0] g;
        logic           found;
        int unsigned    idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && v[IDW'(idx)]) begin
                g     = IDW'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        grant      = rr_pick(req_valid, rr_ptr_q);
        req_sel.a  = req_a[DATA_W*32'(grant) +: DATA_W];
        req_sel.b  = req_b[SHAMT_W*32'(grant) +: SHAMT_W];
        req_sel.op = req_op[OP_W*32'(grant) +: OP_W];
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake decode; req_ready is held low while in reset
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rstn && (|req_valid)) begin
                    req_ready = N_REQ'(1) << grant;
                    accept    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready[id_q]) begin
                    rsp_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign extn   = (op_q.op == OP_SRA) & op_q.a[31];
    assign result = use_rshift(op_q.op) ? rshift_s : lshift_s;

    shifter u_shifter (
        .a        (op_q.a),
        .b        (op_q.b),
        .extn     (extn),
        .lshift_s (lshift_s),
        .rshift_s (rshift_s)
    );

    // Operand capture, result/response registers and round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q      <= '0;
            id_q      <= '0;
            rr_ptr_q  <= IDW'(N_REQ - 1);
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            if (accept) begin
                op_q <= req_sel;
                id_q <= grant;
            end
            if (state_q == S_SHIFT) begin
                rsp_data  <= result;
                rsp_valid <= N_REQ'(1) << id_q;
            end
            if (rsp_done) begin
                rsp_valid <= '0;
                rr_ptr_q  <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized checks of shift_arbiter with two requesters.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_a;
    logic [9:0]  req_b;
    logic [3:0]  req_op;
    logic [31:0] rsp_data;
    logic        busy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.N_REQ(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [1:0] oh(input int i);
        return 2'(1 << i);
    endfunction

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                              input logic [1:0] op);
        case (op)
            2'b01:   return a >> b;
            2'b10:   return 32'($signed(a) >>> b);
            default: return a << b;
        endcase
    endfunction

    function automatic int ref_pick(input logic [1:0] v, input int ptr);
        for (int k = 1; k <= 2; k++)
            if (v[(ptr + k) % 2]) return (ptr + k) % 2;
        return 0;
    endfunction

    task automatic set_pl(input int i, input logic [31:0] a, input logic [4:0] b,
                          input logic [1:0] op);
        req_a[32*i +: 32] = a;
        req_b[5*i +: 5]   = b;
        req_op[2*i +: 2]  = op;
    endtask

    // One full transaction from IDLE; others in v stay pending afterwards.
    task automatic txn(input logic [1:0] v, input int exp_id, input logic [31:0] exp_d,
                       input int hold, input string tag);
        req_valid = v;
        #1;
        chk({tag, ".grant"}, 32'(req_ready), 32'(oh(exp_id)));
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        step();
        req_valid = v & ~oh(exp_id);
        #1;
        chk({tag, ".shift_busy"}, 32'(busy), 32'd1);
        chk({tag, ".shift_rdy"}, 32'(req_ready), 32'd0);
        chk({tag, ".shift_rv"}, 32'(rsp_valid), 32'd0);
        step();
        chk({tag, ".rv"}, 32'(rsp_valid), 32'(oh(exp_id)));
        chk({tag, ".data"}, rsp_data, exp_d);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = ~oh(exp_id);
            step();
            chk({tag, ".hold_rv"}, 32'(rsp_valid), 32'(oh(exp_id)));
            chk({tag, ".hold_data"}, rsp_data, exp_d);
            chk({tag, ".hold_busy"}, 32'(busy), 32'd1);
            chk({tag, ".hold_rdy"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = oh(exp_id);
        step();
        rsp_ready = 2'b00;
        #1;
        chk({tag, ".done_rv"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0]  v;
        int          m_ptr, id;
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  op;

        rstn      = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        // Reset state, with a request already waiting
        set_pl(0, 32'h0000_00F0, 5'd4, 2'b00);
        req_valid = 2'b01;
        #1;
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_data", rsp_data, 32'd0);
        step();
        step();
        rstn = 1'b1;

        txn(2'b01, 0, 32'h0000_0F00, 0, "t1");

        // Both requesters contend; pointer is at 0 so requester 1 leads
        set_pl(0, 32'h0000_0001, 5'd1, 2'b00);
        set_pl(1, 32'h0000_0080, 5'd3, 2'b01);
        txn(2'b11, 1, 32'h0000_0010, 0, "t2a");
        txn(2'b11, 0, 32'h0000_0002, 0, "t2b");
        txn(2'b11, 1, 32'h0000_0010, 0, "t2c");
        txn(2'b11, 0, 32'h0000_0002, 0, "t2d");

        set_pl(1, 32'h8000_0000, 5'd31, 2'b10);
        txn(2'b10, 1, 32'hFFFF_FFFF, 0, "t3_sra31");
        set_pl(1, 32'h8000_0000, 5'd31, 2'b01);
        txn(2'b10, 1, 32'h0000_0001, 0, "t3_srl31");
        set_pl(1, 32'h8000_0000, 5'd0, 2'b10);
        txn(2'b10, 1, 32'h8000_0000, 0, "t3_sra0");
        set_pl(1, 32'hDEAD_BEEF, 5'd0, 2'b00);
        txn(2'b10, 1, 32'hDEAD_BEEF, 0, "t3_sll0");
        set_pl(1, 32'h1234_5678, 5'd0, 2'b01);
        txn(2'b10, 1, 32'h1234_5678, 0, "t3_srl0");

        set_pl(0, 32'h0000_0001, 5'd3, 2'b11);
        txn(2'b01, 0, 32'h0000_0008, 0, "t6_rsv");
        set_pl(1, 32'h7FFF_FFFF, 5'd4, 2'b10);
        txn(2'b10, 1, 32'h07FF_FFFF, 0, "t6_sra_pos");

        // Back-pressure with requester 1 pending and its rsp_ready bit toggled
        set_pl(0, 32'h0000_1234, 5'd8, 2'b00);
        set_pl(1, 32'hF000_0000, 5'd4, 2'b10);
        txn(2'b11, 0, 32'h0012_3400, 5, "t4_hold");
        txn(2'b10, 1, 32'hFF00_0000, 0, "t4_next");
        txn(2'b01, 0, 32'h0012_3400, 0, "t4_ptr0");

        // Reset while in SHIFT drops the operation and restores priority to requester 0
        req_valid = 2'b01;
        #1;
        chk("t5.grant", 32'(req_ready), 32'(oh(0)));
        step();
        req_valid = 2'b11;
        #1;
        chk("t5.in_shift", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t5.rst_busy", 32'(busy), 32'd0);
        chk("t5.rst_rdy", 32'(req_ready), 32'd0);
        step();
        chk("t5.rst_rv", 32'(rsp_valid), 32'd0);
        req_valid = 2'b00;
        step();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5.no_rsp", 32'(rsp_valid), 32'd0);
        end
        txn(2'b11, 0, 32'h0012_3400, 0, "t5_first");

        // Random soak against a reference model
        v     = 2'b10;
        m_ptr = 0;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r]) begin
                    a  = $urandom;
                    b  = 5'($urandom_range(0, 31));
                    op = 2'($urandom_range(0, 3));
                    set_pl(r, a, b, op);
                    v[r] = 1'($urandom_range(0, 1));
                end
            end
            if (v == 2'b00) v = 2'($urandom_range(1, 3));
            id = ref_pick(v, m_ptr);
            txn(v, id, ref_shift(req_a[32*id +: 32], req_b[5*id +: 5], req_op[2*id +: 2]),
                $urandom_range(0, 2), "soak");
            v     = v & ~oh(id);
            m_ptr = id;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
